bram_line_mover: RTL and testbench
==================================

// Module: bram_line_mover
// PURPOSE
//  Line-granular port master for one single-port no-change BRAM (1-cycle read, LOW_LATENCY).
//  Sits between the cache controller and the backing BRAM.
//  FILL: reads one LINE_WORDS-word line out of the BRAM and streams it to the cache.
//  WB: accepts a LINE_WORDS-word stream from the cache and writes it into the BRAM.
// PARAMETERS
//  DATA_W      32    BRAM/stream word width
//  ADDR_W      12    BRAM word address width (4096 words)
//  LINE_WORDS  8     words per line; power of 2, >=2; OFF_W = clog2(LINE_WORDS)
// PORTS
//  clka        in   1               clock; the only clock in the block
//  rsta        in   1               reset, synchronous, active-high
//  req_valid   in   1               line request valid
//  req_ready   out  1               request accepted when valid&&ready
//  req_write   in   1               1 = WB (write line), 0 = FILL (read line)
//  req_line    in   ADDR_W-OFF_W    line index
//  rd_valid    out  1               FILL word valid
//  rd_ready    in   1               cache accepts FILL word
//  rd_data     out  DATA_W          FILL word (= bram_douta)
//  rd_idx      out  OFF_W           word offset of rd_data within the line
//  rd_last     out  1               rd_data is word LINE_WORDS-1
//  wr_valid    in   1               WB word valid
//  wr_ready    out  1               WB word accepted when valid&&ready
//  wr_data     in   DATA_W          WB word; words arrive in offset order 0..LINE_WORDS-1
//  done        out  1               1-cycle pulse: line operation complete
//  bram_addra  out  ADDR_W          BRAM address = {line_reg, offset}
//  bram_dina   out  DATA_W          BRAM write data
//  bram_wea    out  1               BRAM write enable
//  bram_ena    out  1               BRAM port enable
//  bram_douta  in   DATA_W          BRAM read data; held while ena=0 or wea=1
// BEHAVIOUR
//  FSM states: IDLE, FILL, WB, FIN; all transitions occur on the rising edge of clka.
//  IDLE: req_ready=1. On req_valid, latch req_line into line_reg, clear counters, go to FILL or WB.
//  Outside IDLE, req_valid is ignored.
//  FILL:
//   - iss_cnt counts reads issued; out_v is set one cycle after each issue.
//   - bram_ena = (iss_cnt<LINE_WORDS) && (!out_v || rd_ready); bram_wea = 0; addr = {line_reg, iss_cnt}.
//   - rd_valid = out_v; rd_data = bram_douta, combinational.
//   - While rd_ready=0, ena stays 0, so rd_data is held by the no-change BRAM.
//   - Throughput is 1 word/cycle. No word is skipped or duplicated.
//   - Handshake on rd_last: go to FIN.
//  WB:
//   - wr_ready = 1.
//   - On wr_valid: ena=1, wea=1, addr={line_reg, wr_cnt}, dina=wr_data; wr_cnt increments.
//   - Handshake on word LINE_WORDS-1: go to FIN.
//  FIN: done=1, req_ready=0. Next state is IDLE.
//  Latency, FILL: request accepted at cycle 0 -> word0 read issued at cycle 1 -> rd_valid at cycle 2.
//   - With rd_ready=1 throughout, done is at cycle LINE_WORDS+2.
//   - Next request can be accepted at cycle LINE_WORDS+3.
//  Latency, WB: done is 1 cycle after the last write.
//  Address arithmetic is concatenation only: no carry out of the line, no wrap into an adjacent line.
//   - The top line (all ones) covers the top LINE_WORDS addresses.
//  Outputs default to 0 whenever not asserted by the current state.
//  Reset (any state, including mid-line):
//   - State = IDLE; counters and out_v cleared.
//   - While rsta=1: req_ready, rd_valid, wr_ready, done, bram_ena and bram_wea are all 0.
//   - In-flight line is abandoned; words already written stay in the BRAM.
//   - rsta is not forwarded to the BRAM.
//   - req_ready=1 on the first cycle after rsta falls.
// TESTING (LINE_WORDS=8, ADDR_W=12, BRAM word k preloaded with 0x1000+k)
//  1. FILL line 5, rd_ready=1 -> rd_valid at cycles 2..9.
//     Data 0x1028..0x102F, rd_idx 0..7, rd_last at cycle 9, done at cycle 10, req_ready=1 at cycle 11.
//  2. FILL line 5, rd_ready=0 in cycles 3-5 -> rd_data held at 0x1029 and bram_ena=0 in those cycles.
//     Exactly 8 handshakes, data in order, no duplicates.
//  3. WB line 2 with data 0xA0..0xA7 and wr_valid gaps -> exactly 8 wea pulses, addr 16..23, done once.
//     A following FILL of line 2 returns 0xA0..0xA7.
//  4. rsta for 1 cycle after the 3rd FILL handshake -> next cycle all outputs idle.
//     A new FILL of line 1 returns 0x1008..0x100F correctly.
//  5. FILL line 511 -> addresses 4088..4095, no wrap to address 0.
//  6. req_valid held high through FILL/FIN with req_write toggling -> only one request accepted per line.
//     The second request is accepted only in IDLE.

Source files
------------

// File: rtl/bram_line_mover.sv
// Line-granular port master for a single-port no-change BRAM with 1-cycle read.
// FILL streams one line out of the BRAM, WB writes one streamed line into it.
module bram_line_mover #(
    parameter int  DATA_W     = 32,
    parameter int  ADDR_W     = 12,
    parameter int  LINE_WORDS = 8,
    localparam int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic                      clka,
    input  logic                      rsta,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-OFF_W-1:0]   req_line,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DATA_W-1:0]         rd_data,
    output logic [OFF_W-1:0]          rd_idx,
    output logic                      rd_last,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      done,
    output logic [ADDR_W-1:0]         bram_addra,
    output logic [DATA_W-1:0]         bram_dina,
    output logic                      bram_wea,
    output logic                      bram_ena,
    input  logic [DATA_W-1:0]         bram_douta
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    logic [1:0]              state_r;
    logic [ADDR_W-OFF_W-1:0] line_r;
    logic [OFF_W:0]          iss_cnt_r;   // extra MSB marks "all words issued"
    logic                    out_v_r;
    logic [OFF_W-1:0]        out_idx_r;
    logic [OFF_W-1:0]        wr_cnt_r;
    logic                    fill_issue_s;

    // Output and BRAM-port decode; reset forces every strobe low in the same cycle.
    always_comb begin
        req_ready    = 1'b0;
        rd_valid     = 1'b0;
        rd_data      = '0;
        rd_idx       = '0;
        rd_last      = 1'b0;
        wr_ready     = 1'b0;
        done         = 1'b0;
        bram_addra   = '0;
        bram_dina    = '0;
        bram_wea     = 1'b0;
        bram_ena     = 1'b0;
        fill_issue_s = 1'b0;
        if (rsta) begin
            fill_issue_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: req_ready = 1'b1;
                ST_FILL: begin
                    // Stalling ena keeps the no-change BRAM holding the presented word.
                    fill_issue_s = !iss_cnt_r[OFF_W] && (!out_v_r || rd_ready);
                    bram_ena     = fill_issue_s;
                    bram_addra   = {line_r, iss_cnt_r[OFF_W-1:0]};
                    rd_valid     = out_v_r;
                    rd_data      = out_v_r ? bram_douta : '0;
                    rd_idx       = out_v_r ? out_idx_r : '0;
                    rd_last      = out_v_r && (&out_idx_r);
                end
                ST_WB: begin
                    wr_ready = 1'b1;
                    if (wr_valid) begin
                        bram_ena   = 1'b1;
                        bram_wea   = 1'b1;
                        bram_addra = {line_r, wr_cnt_r};
                        bram_dina  = wr_data;
                    end else begin
                        bram_ena   = 1'b0;
                        bram_wea   = 1'b0;
                    end
                end
                ST_FIN:  done = 1'b1;
                default: req_ready = 1'b0;
            endcase
        end
    end

    // State, line register and word counters.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_r   <= ST_IDLE;
            line_r    <= '0;
            iss_cnt_r <= '0;
            out_v_r   <= 1'b0;
            out_idx_r <= '0;
            wr_cnt_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        line_r    <= req_line;
                        iss_cnt_r <= '0;
                        out_v_r   <= 1'b0;
                        out_idx_r <= '0;
                        wr_cnt_r  <= '0;
                        state_r   <= req_write ? ST_WB : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (fill_issue_s) begin
                        iss_cnt_r <= iss_cnt_r + 1'b1;
                        out_v_r   <= 1'b1;
                        out_idx_r <= iss_cnt_r[OFF_W-1:0];
                    end else if (out_v_r && rd_ready) begin
                        out_v_r   <= 1'b0;
                    end
                    if (rd_valid && rd_ready && rd_last) begin
                        state_r <= ST_FIN;
                    end
                end
                ST_WB: begin
                    if (wr_valid) begin
                        wr_cnt_r <= wr_cnt_r + 1'b1;
                        if (&wr_cnt_r) begin
                            state_r <= ST_FIN;
                        end
                    end
                end
                ST_FIN:  state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_line_mover.sv
// Directed + randomized bench for bram_line_mover with a behavioural BRAM and a
// line-level reference memory that is updated once per completed write-back.
module tb_bram_line_mover;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int LW = 8;
    localparam int OW = 3;

    logic          clka = 1'b0;
    logic          rsta;
    logic          req_valid, req_ready, req_write;
    logic [AW-OW-1:0] req_line;
    logic          rd_valid, rd_ready, rd_last;
    logic [DW-1:0] rd_data;
    logic [OW-1:0] rd_idx;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          done;
    logic [AW-1:0] bram_addra;
    logic [DW-1:0] bram_dina;
    logic          bram_wea, bram_ena;
    logic [DW-1:0] bram_douta = '0;

    logic [DW-1:0] mem     [0:4095];
    logic [DW-1:0] ref_mem [0:4095];
    logic [DW-1:0] wb_data [0:LW-1];
    int total = 0;
    int bad   = 0;

    always #5 clka = ~clka;

    bram_line_mover dut (
        .clka(clka), .rsta(rsta),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_line(req_line),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_idx(rd_idx), .rd_last(rd_last),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .done(done),
        .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
        .bram_ena(bram_ena), .bram_douta(bram_douta)
    );

    // Single-port no-change BRAM: read data only updates on an enabled read.
    always @(posedge clka) begin
        if (bram_ena) begin
            if (bram_wea) mem[bram_addra] <= bram_dina;
            else          bram_douta      <= mem[bram_addra];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clka);
        #1;
    endtask

    // mode 0: rd_ready always 1; mode 1: rd_ready low in cycles 3..5; mode 2: random.
    task automatic do_fill(input int line, input int mode, input int abort_n, input bit hold_req);
        int got, iss;
        bit fin, prev_last;
        req_valid = 1'b1; req_write = 1'b0; req_line = line[AW-OW-1:0]; rd_ready = 1'b1; wr_valid = 1'b0;
        #1;
        chk("fill_accept", req_ready, 1'b1);
        cyc();
        got = 0; iss = 0; fin = 1'b0; prev_last = 1'b0;
        for (int c = 1; c < 300 && !fin; c++) begin
            if (hold_req) begin
                req_valid = 1'b1;
                req_write = c[0];
            end else begin
                req_valid = 1'b0;
            end
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = !(c >= 3 && c <= 5);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (abort_n > 0 && got == abort_n) begin
                rsta = 1'b1;
                #1;
                chk("rst_outs", {req_ready, rd_valid, wr_ready, done, bram_ena, bram_wea}, 6'b000000);
                cyc();
                rsta = 1'b0; req_valid = 1'b0;
                #1;
                chk("rst_idle", {req_ready, rd_valid, wr_ready, done, bram_ena, bram_wea}, 6'b100000);
                cyc();
                return;
            end
            #1;
            chk("fill_busy", req_ready, 1'b0);
            chk("fill_wea", bram_wea, 1'b0);
            chk("fill_done_t", done, prev_last);
            if (bram_ena) begin
                chk("fill_addr", bram_addra, line * LW + iss);
                iss++;
            end
            if (mode == 1 && c >= 3 && c <= 5) begin
                chk("stall_ena", bram_ena, 1'b0);
                chk("stall_valid", rd_valid, 1'b1);
                chk("stall_data", rd_data, ref_mem[line * LW + got]);
            end
            if (mode == 0) chk("fill_valid_t", rd_valid, (c >= 2 && c <= LW + 1));
            prev_last = 1'b0;
            if (rd_valid && rd_ready) begin
                chk("fill_data", rd_data, ref_mem[line * LW + got]);
                chk("fill_idx", rd_idx, got);
                chk("fill_last", rd_last, (got == LW - 1));
                prev_last = rd_last;
                got++;
            end
            if (done) begin
                chk("fill_count", got, LW);
                chk("fill_issued", iss, LW);
                if (mode == 0) chk("fill_done_cycle", c, LW + 2);
                fin = 1'b1;
            end
            cyc();
        end
        chk("fill_finished", fin, 1'b1);
    endtask

    // gap_mode 0: no gaps; 1: valid on odd cycles only; 2: random gaps.
    task automatic do_wb(input int line, input int gap_mode);
        int sent, weas;
        bit fin, prev_last;
        req_valid = 1'b1; req_write = 1'b1; req_line = line[AW-OW-1:0]; wr_valid = 1'b0; rd_ready = 1'b0;
        #1;
        chk("wb_accept", req_ready, 1'b1);
        cyc();
        req_valid = 1'b0;
        sent = 0; weas = 0; fin = 1'b0; prev_last = 1'b0;
        for (int c = 1; c < 300 && !fin; c++) begin
            if (sent < LW) begin
                case (gap_mode)
                    0:       wr_valid = 1'b1;
                    1:       wr_valid = c[0];
                    default: wr_valid = ($urandom_range(0, 2) != 0);
                endcase
                wr_data = wb_data[sent];
            end else begin
                wr_valid = 1'b0;
                wr_data  = $urandom;
            end
            #1;
            chk("wb_done_t", done, prev_last);
            prev_last = 1'b0;
            if (done) begin
                chk("wb_fin_ready", wr_ready, 1'b0);
                chk("wb_fin_wea", bram_wea, 1'b0);
                chk("wb_count", weas, LW);
                fin = 1'b1;
            end else begin
                chk("wb_ready", wr_ready, 1'b1);
                chk("wb_wea", bram_wea, wr_valid);
                chk("wb_ena", bram_ena, wr_valid);
                if (wr_valid) begin
                    chk("wb_addr", bram_addra, line * LW + sent);
                    chk("wb_dina", bram_dina, wb_data[sent]);
                    weas++;
                    prev_last = (sent == LW - 1);
                    sent++;
                end
            end
            cyc();
        end
        chk("wb_finished", fin, 1'b1);
        wr_valid = 1'b0;
        for (int k = 0; k < LW; k++) ref_mem[line * LW + k] = wb_data[k];
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) begin
            mem[k]     = 32'h1000 + k;
            ref_mem[k] = 32'h1000 + k;
        end
        rsta = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_line = '0;
        rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
        cyc();
        cyc();
        chk("reset_outs", {req_ready, rd_valid, wr_ready, done, bram_ena, bram_wea}, 6'b000000);
        rsta = 1'b0;
        #1;
        chk("reset_idle", {req_ready, rd_valid, wr_ready, done, bram_ena, bram_wea}, 6'b100000);
        cyc();

        do_fill(5, 0, 0, 1'b0);
        #1;
        chk("t1_ready_after", req_ready, 1'b1);
        cyc();

        do_fill(5, 1, 0, 1'b0);

        for (int k = 0; k < LW; k++) wb_data[k] = 32'hA0 + k;
        do_wb(2, 1);
        do_fill(2, 0, 0, 1'b0);

        do_fill(3, 0, 3, 1'b0);
        do_fill(1, 0, 0, 1'b0);

        do_fill(511, 0, 0, 1'b0);

        do_fill(6, 0, 0, 1'b1);
        do_fill(7, 0, 0, 1'b0);

        for (int n = 0; n < 16; n++) begin
            int line;
            line = $urandom_range(0, 511);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < LW; k++) wb_data[k] = $urandom;
                do_wb(line, 2);
                do_fill(line, 2, 0, 1'b0);
            end else begin
                do_fill(line, 2, 0, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
